// File: rtl/light_ramp_ctrl.sv
// light_ramp_ctrl: LED brightness ramp sequencer.
// Produces a prescaled triangle level (up, hold high, down, hold low) for a
// programmed number of cycles, then stops; also drives a registered PWM of
// the level. Configuration is taken through a valid/ready port while idle.
//
// Handshake: a config word transfers on a clock edge where cfg_valid and
// cfg_ready are both high; cfg_ready is high exactly while the sequencer is
// idle, so a config offered during a run is held off (not dropped) by the
// source until the run ends. No combinational path from cfg_valid to cfg_ready.
module light_ramp_ctrl #(
    parameter int LEVEL_W = 8,
    parameter int DIV_W   = 16,
    parameter int HOLD_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [DIV_W-1:0]   cfg_div,
    input  logic [LEVEL_W-1:0] cfg_peak,
    input  logic [HOLD_W-1:0]  cfg_hold_hi,
    input  logic [HOLD_W-1:0]  cfg_hold_lo,
    input  logic [7:0]         cfg_cycles,
    input  logic               start,
    input  logic               stop,
    output logic               busy,
    output logic               done,
    output logic [LEVEL_W-1:0] level,
    output logic               pwm_out,
    output logic [2:0]         state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_UP      = 3'd1,
        S_HOLD_HI = 3'd2,
        S_DOWN    = 3'd3,
        S_HOLD_LO = 3'd4
    } state_t;

    state_t             state, state_n;
    logic [LEVEL_W-1:0] level_n;
    logic               busy_n, done_n;
    logic [DIV_W-1:0]   presc, presc_n;
    logic [HOLD_W-1:0]  hold_cnt, hold_cnt_n;
    logic [7:0]         cyc, cyc_n;
    logic               stop_pend, stop_pend_n;
    logic               tick;
    logic               cyc_last;

    // Shadow configuration, only written while idle
    logic [DIV_W-1:0]   div_q;
    logic [LEVEL_W-1:0] peak_q;
    logic [HOLD_W-1:0]  hold_hi_q, hold_lo_q;
    logic [7:0]         cycles_q;

    logic [LEVEL_W-1:0] pwm_cnt;

    assign cfg_ready = (state == S_IDLE);
    assign state_dbg = state;
    assign tick      = (state != S_IDLE) && (presc == div_q);
    assign cyc_last  = (cycles_q != 8'd0) && (cyc == cycles_q - 8'd1);

    // Latch config on handshake; a zero peak is stored as 1
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q     <= '0;
            peak_q    <= '1;
            hold_hi_q <= '0;
            hold_lo_q <= '0;
            cycles_q  <= '0;
        end else if (cfg_valid && cfg_ready) begin
            div_q     <= cfg_div;
            peak_q    <= (cfg_peak == '0) ? LEVEL_W'(1) : cfg_peak;
            hold_hi_q <= cfg_hold_hi;
            hold_lo_q <= cfg_hold_lo;
            cycles_q  <= cfg_cycles;
        end
    end

    // FSM state and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            level     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            presc     <= '0;
            hold_cnt  <= '0;
            cyc       <= '0;
            stop_pend <= 1'b0;
        end else begin
            state     <= state_n;
            level     <= level_n;
            busy      <= busy_n;
            done      <= done_n;
            presc     <= presc_n;
            hold_cnt  <= hold_cnt_n;
            cyc       <= cyc_n;
            stop_pend <= stop_pend_n;
        end
    end

    // Next-state and next-output logic for the ramp sequencer
    always_comb begin
        state_n     = state;
        level_n     = level;
        busy_n      = busy;
        done_n      = 1'b0;
        presc_n     = presc;
        hold_cnt_n  = hold_cnt;
        cyc_n       = cyc;
        stop_pend_n = stop_pend | (stop && (state != S_IDLE));

        // Prescaler free-runs 0..div while active
        if (state != S_IDLE) begin
            presc_n = tick ? '0 : presc + DIV_W'(1);
        end

        case (state)
            S_IDLE: begin
                stop_pend_n = 1'b0;
                presc_n     = '0;
                hold_cnt_n  = '0;
                if (start) begin
                    state_n = S_UP;
                    level_n = '0;
                    cyc_n   = '0;
                    busy_n  = 1'b1;
                end
            end

            S_UP: begin
                if (tick) begin
                    if (level < peak_q) begin
                        level_n = level + LEVEL_W'(1);
                    end
                    if (level >= peak_q - LEVEL_W'(1)) begin
                        hold_cnt_n = '0;
                        state_n    = (hold_hi_q != '0) ? S_HOLD_HI : S_DOWN;
                    end
                end
            end

            S_HOLD_HI: begin
                if (tick) begin
                    if (hold_cnt == hold_hi_q - HOLD_W'(1)) begin
                        hold_cnt_n = '0;
                        state_n    = S_DOWN;
                    end else begin
                        hold_cnt_n = hold_cnt + HOLD_W'(1);
                    end
                end
            end

            S_DOWN: begin
                if (tick) begin
                    if (level != '0) begin
                        level_n = level - LEVEL_W'(1);
                    end
                    // Level reaches zero: one full cycle completed
                    if (level <= LEVEL_W'(1)) begin
                        if (cyc != 8'hFF) begin
                            cyc_n = cyc + 8'd1;
                        end
                        hold_cnt_n = '0;
                        if (cyc_last || stop_pend) begin
                            state_n     = S_IDLE;
                            busy_n      = 1'b0;
                            done_n      = 1'b1;
                            stop_pend_n = 1'b0;
                            presc_n     = '0;
                        end else begin
                            state_n = (hold_lo_q != '0) ? S_HOLD_LO : S_UP;
                        end
                    end
                end
            end

            S_HOLD_LO: begin
                if (stop_pend) begin
                    state_n     = S_IDLE;
                    busy_n      = 1'b0;
                    done_n      = 1'b1;
                    stop_pend_n = 1'b0;
                    presc_n     = '0;
                    hold_cnt_n  = '0;
                end else if (tick) begin
                    if (hold_cnt == hold_lo_q - HOLD_W'(1)) begin
                        hold_cnt_n = '0;
                        state_n    = S_UP;
                    end else begin
                        hold_cnt_n = hold_cnt + HOLD_W'(1);
                    end
                end
            end

            default: begin
                state_n = S_IDLE;
                busy_n  = 1'b0;
                level_n = '0;
            end
        endcase
    end

    // Free-running PWM counter and registered comparator
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt <= '0;
            pwm_out <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + LEVEL_W'(1);
            pwm_out <= (pwm_cnt < level);
        end
    end

endmodule

// File: tb/tb_light_ramp_ctrl.sv
// Directed testbench for light_ramp_ctrl.
module tb_light_ramp_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [15:0] cfg_div;
    logic [7:0]  cfg_peak;
    logic [15:0] cfg_hold_hi;
    logic [15:0] cfg_hold_lo;
    logic [7:0]  cfg_cycles;
    logic        start;
    logic        stop;
    logic        busy;
    logic        done;
    logic [7:0]  level;
    logic        pwm_out;
    logic [2:0]  state_dbg;

    int checks = 0;
    int errors = 0;

    light_ramp_ctrl #(.LEVEL_W(8), .DIV_W(16), .HOLD_W(16)) dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_div(cfg_div), .cfg_peak(cfg_peak),
        .cfg_hold_hi(cfg_hold_hi), .cfg_hold_lo(cfg_hold_lo),
        .cfg_cycles(cfg_cycles),
        .start(start), .stop(stop),
        .busy(busy), .done(done), .level(level),
        .pwm_out(pwm_out), .state_dbg(state_dbg)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cfg(input logic [15:0] d, input logic [7:0] p,
                             input logic [15:0] hh, input logic [15:0] hl,
                             input logic [7:0] c);
        cfg_valid   = 1'b1;
        cfg_div     = d;
        cfg_peak    = p;
        cfg_hold_hi = hh;
        cfg_hold_lo = hl;
        cfg_cycles  = c;
    endtask

    task automatic clear_inputs();
        cfg_valid = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        cfg_div = '0; cfg_peak = '0; cfg_hold_hi = '0; cfg_hold_lo = '0; cfg_cycles = '0;
        repeat (3) step();
        rst = 1'b0;
        step();
        checks++;
        if (level !== 8'd0 || busy !== 1'b0 || done !== 1'b0 || pwm_out !== 1'b0 ||
            cfg_ready !== 1'b1 || state_dbg !== 3'd0) begin
            errors++;
            $display("FAIL reset_state: level=%0d busy=%b done=%b pwm=%b ready=%b st=%0d want 0 0 0 0 1 0",
                     level, busy, done, pwm_out, cfg_ready, state_dbg);
        end
    endtask

    // div=0 peak=3 holds=0 cycles=1, config and start in the same cycle
    task automatic test_basic_ramp();
        logic [7:0] exp_lv [6] = '{8'd1, 8'd2, 8'd3, 8'd2, 8'd1, 8'd0};
        drive_cfg(16'd0, 8'd3, 16'd0, 16'd0, 8'd1);
        start = 1'b1;
        step();
        clear_inputs();
        checks++;
        if (busy !== 1'b1 || level !== 8'd0 || cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_start: busy=%b level=%0d ready=%b want 1 0 0", busy, level, cfg_ready);
        end
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (level !== exp_lv[i] || done !== (i == 5) || busy !== (i != 5)) begin
                errors++;
                $display("FAIL basic_ramp[%0d]: level=%0d done=%b busy=%b want %0d %b %b",
                         i, level, done, busy, exp_lv[i], (i == 5), (i != 5));
            end
        end
        step();
        checks++;
        if (done !== 1'b0 || cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_done_pulse: done=%b ready=%b want 0 1", done, cfg_ready);
        end
    endtask

    // div=3 peak=2 hold_hi=2 hold_lo=0 cycles=1
    task automatic test_prescale();
        int hi_cnt = 0;
        int done_cnt = 0;
        logic [7:0] exp_l;
        drive_cfg(16'd3, 8'd2, 16'd2, 16'd0, 8'd1);
        step();
        clear_inputs();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int e = 1; e <= 30; e++) begin
            step();
            if (e < 4)       exp_l = 8'd0;
            else if (e < 8)  exp_l = 8'd1;
            else if (e < 20) exp_l = 8'd2;
            else if (e < 24) exp_l = 8'd1;
            else             exp_l = 8'd0;
            if (state_dbg === 3'd2) hi_cnt++;
            if (done === 1'b1) done_cnt++;
            checks++;
            if (level !== exp_l || done !== (e == 24)) begin
                errors++;
                $display("FAIL prescale_edge%0d: level=%0d done=%b want %0d %b", e, level, done, exp_l, (e == 24));
            end
        end
        checks++;
        if (hi_cnt != 8) begin
            errors++;
            $display("FAIL prescale_hold_hi: clocks=%0d want 8", hi_cnt);
        end
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL prescale_done_count: got %0d want 1", done_cnt);
        end
    endtask

    // cycles=0 peak=4 div=0: stop while rising at level 3
    task automatic test_stop();
        logic [7:0] exp_down [4] = '{8'd3, 8'd2, 8'd1, 8'd0};
        int bad = 0;
        drive_cfg(16'd0, 8'd4, 16'd0, 16'd0, 8'd0);
        start = 1'b1;
        step();
        clear_inputs();
        repeat (3) step();
        checks++;
        if (level !== 8'd3) begin
            errors++;
            $display("FAIL stop_pre: level=%0d want 3", level);
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        checks++;
        if (level !== 8'd4 || busy !== 1'b1) begin
            errors++;
            $display("FAIL stop_peak: level=%0d busy=%b want 4 1", level, busy);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (level !== exp_down[i] || done !== (i == 3) || busy !== (i != 3)) begin
                errors++;
                $display("FAIL stop_down[%0d]: level=%0d done=%b busy=%b want %0d %b %b",
                         i, level, done, busy, exp_down[i], (i == 3), (i != 3));
            end
        end
        for (int i = 0; i < 10; i++) begin
            step();
            if (level !== 8'd0 || busy !== 1'b0 || done !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL stop_stays_idle: bad_clocks=%0d want 0", bad);
        end
    endtask

    // Peak 0 behaves as 1; config offered while busy is not accepted
    task automatic test_peak_zero();
        logic [7:0] exp_lv [4] = '{8'd1, 8'd0, 8'd1, 8'd0};
        for (int run = 0; run < 2; run++) begin
            if (run == 0) drive_cfg(16'd0, 8'd0, 16'd0, 16'd0, 8'd2);
            start = 1'b1;
            step();
            clear_inputs();
            for (int i = 0; i < 4; i++) begin
                if (run == 0 && i == 0) begin
                    drive_cfg(16'd0, 8'd5, 16'd3, 16'd3, 8'd1);
                    checks++;
                    if (cfg_ready !== 1'b0) begin
                        errors++;
                        $display("FAIL busy_cfg_ready: ready=%b want 0", cfg_ready);
                    end
                end
                step();
                cfg_valid = 1'b0;
                checks++;
                if (level !== exp_lv[i] || done !== (i == 3)) begin
                    errors++;
                    $display("FAIL peak_zero_run%0d[%0d]: level=%0d done=%b want %0d %b",
                             run, i, level, done, exp_lv[i], (i == 3));
                end
            end
            step();
        end
    endtask

    // Stop alone in idle and stop with start are ignored; start while busy is ignored
    task automatic test_back_to_back();
        logic [7:0] exp_lv [8] = '{8'd1, 8'd2, 8'd1, 8'd0, 8'd1, 8'd2, 8'd1, 8'd0};
        stop = 1'b1;
        step();
        drive_cfg(16'd0, 8'd2, 16'd0, 16'd0, 8'd2);
        start = 1'b1;
        step();
        clear_inputs();
        for (int i = 0; i < 8; i++) begin
            if (i == 2) start = 1'b1;
            step();
            start = 1'b0;
            checks++;
            if (level !== exp_lv[i] || done !== (i == 7) || busy !== (i != 7)) begin
                errors++;
                $display("FAIL b2b[%0d]: level=%0d done=%b busy=%b want %0d %b %b",
                         i, level, done, busy, exp_lv[i], (i == 7), (i != 7));
            end
        end
        step();
        checks++;
        if (busy !== 1'b0 || level !== 8'd0) begin
            errors++;
            $display("FAIL b2b_no_restart: busy=%b level=%0d want 0 0", busy, level);
        end
    endtask

    // Reset in HOLD_HI, then a run with default config (peak 255, endless until stop)
    task automatic test_reset_mid_run();
        int edges = 0;
        logic seen = 1'b0;
        drive_cfg(16'd0, 8'd2, 16'd100, 16'd0, 8'd1);
        start = 1'b1;
        step();
        clear_inputs();
        repeat (4) step();
        checks++;
        if (state_dbg !== 3'd2 || level !== 8'd2) begin
            errors++;
            $display("FAIL rst_pre_hold_hi: state=%0d level=%0d want 2 2", state_dbg, level);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (level !== 8'd0 || busy !== 1'b0 || pwm_out !== 1'b0 || cfg_ready !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_run: level=%0d busy=%b pwm=%b ready=%b done=%b want 0 0 0 1 0",
                     level, busy, pwm_out, cfg_ready, done);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (200) step();
        checks++;
        if (level !== 8'd200 || busy !== 1'b1) begin
            errors++;
            $display("FAIL default_cfg_ramp: level=%0d busy=%b want 200 1", level, busy);
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        edges = 201;
        while (!seen && edges < 800) begin
            step();
            edges++;
            if (done === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen || edges != 510 || level !== 8'd0) begin
            errors++;
            $display("FAIL default_cfg_stop: done_seen=%b edge=%0d level=%0d want 1 510 0", seen, edges, level);
        end
    endtask

    // Level 64 held: pwm high 64 of 256 clocks; idle gives constant 0
    task automatic test_pwm();
        int hi = 0;
        drive_cfg(16'd0, 8'd64, 16'd1000, 16'd0, 8'd1);
        start = 1'b1;
        step();
        clear_inputs();
        repeat (70) step();
        checks++;
        if (level !== 8'd64 || state_dbg !== 3'd2) begin
            errors++;
            $display("FAIL pwm_level: level=%0d state=%0d want 64 2", level, state_dbg);
        end
        for (int i = 0; i < 256; i++) begin
            step();
            if (pwm_out === 1'b1) hi++;
        end
        checks++;
        if (hi != 64) begin
            errors++;
            $display("FAIL pwm_duty_64: high=%0d want 64", hi);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        hi = 0;
        for (int i = 0; i < 256; i++) begin
            step();
            if (pwm_out === 1'b1) hi++;
        end
        checks++;
        if (hi != 0) begin
            errors++;
            $display("FAIL pwm_level0: high=%0d want 0", hi);
        end
    endtask

    initial begin
        test_reset();
        test_basic_ramp();
        test_prescale();
        test_stop();
        test_peak_zero();
        test_back_to_back();
        test_reset_mid_run();
        test_pwm();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
